frag_serializer: RTL and testbench

- Transmit-side counterpart to the 4-lane sample-test hit stream.
- Accepts 4-lane hit groups (R18) with a per-lane valid mask and an end-of-triangle flag.
- Buffers the groups, then emits one fragment per cycle (R19) toward the z-buffer/shader interface under downstream halt backpressure.
- Marks the last beat of each triangle with a done flag and that triangle's total fragment count.

---
 rtl/frag_serializer_if.sv | 43 ++++
 rtl/frag_serializer.sv | 173 +++++++++++++++++
 tb/tb_frag_serializer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frag_serializer_if.sv
// Bus bundle for frag_serializer: R18 hit-group handshake in, R19 fragment stream out.
// With FRAG_STATS_EN defined it also carries the running done/fragment totals.
interface frag_serializer_if #(
   parameter int SIGFIG = 24,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int LANES  = 4,
   parameter int CNT_W  = 32
);
   logic [AXIS-1:0][LANES-1:0][SIGFIG-1:0] hit_R18S;
   logic [COLORS-1:0][SIGFIG-1:0]          color_R18U;
   logic [LANES-1:0]                       hit_valid_R18H;
   logic                                   tri_end_R18H;
   logic                                   in_valid_R18H;
   logic                                   in_ready_R18H;

   logic [AXIS-1:0][SIGFIG-1:0]            hit_R19S;
   logic [COLORS-1:0][SIGFIG-1:0]          color_R19U;
   logic                                   frag_valid_R19H;
   logic                                   done_R19H;
   logic [CNT_W-1:0]                       tri_hits_R19U;
   logic                                   halt_R19H;
`ifdef FRAG_STATS_EN
   logic [CNT_W-1:0]                       stat_tri_R19U;
   logic [CNT_W-1:0]                       stat_frag_R19U;
`endif

   modport master (
      output hit_R18S, color_R18U, hit_valid_R18H, tri_end_R18H, in_valid_R18H, halt_R19H,
      input  in_ready_R18H, hit_R19S, color_R19U, frag_valid_R19H, done_R19H, tri_hits_R19U
`ifdef FRAG_STATS_EN
      , stat_tri_R19U, stat_frag_R19U
`endif
   );

   modport slave (
      input  hit_R18S, color_R18U, hit_valid_R18H, tri_end_R18H, in_valid_R18H, halt_R19H,
      output in_ready_R18H, hit_R19S, color_R19U, frag_valid_R19H, done_R19H, tri_hits_R19U
`ifdef FRAG_STATS_EN
      , stat_tri_R19U, stat_frag_R19U
`endif
   );
endinterface

// File: rtl/frag_serializer.sv
// Buffers 4-lane hit groups and serializes them into one fragment per cycle under halt backpressure.
// Optional FRAG_STATS_EN adds free-running done-beat and fragment-beat totals.
module frag_serializer #(
   parameter int SIGFIG     = 24,
   parameter int RADIX      = 10,
   parameter int AXIS       = 3,
   parameter int COLORS     = 3,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 32
) (
   input logic              clk,
   input logic              rst,
   frag_serializer_if.slave bus
);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int UW     = PTR_W + 1;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   // Fraction bits only ride along with the coordinates; reject nonsense at elaboration.
   if (RADIX > SIGFIG) begin : g_radix_check
      $error("frag_serializer: RADIX exceeds SIGFIG");
   end

   typedef enum logic [1:0] {IDLE, SER, TERM} state_t;

   state_t state, state_next;

   logic [AXIS-1:0][LANES-1:0][SIGFIG-1:0] fifo_hit   [FIFO_DEPTH];
   logic [COLORS-1:0][SIGFIG-1:0]          fifo_color [FIFO_DEPTH];
   logic [LANES-1:0]                       fifo_mask  [FIFO_DEPTH];
   logic                                   fifo_end   [FIFO_DEPTH];

   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [UW-1:0]    used, used_next;
   logic             ready_q;

   logic [AXIS-1:0][SIGFIG-1:0]   hit_q, hit_next;
   logic [COLORS-1:0][SIGFIG-1:0] color_q, color_next;
   logic                          done_q, done_next;
   logic [CNT_W-1:0]              hits_q, hits_next;
   logic [CNT_W-1:0]              count, count_next, count_inc;

   logic             push, pop, clear_lane, have_head;
   logic [LANES-1:0] head_mask, rest_mask;
   logic [LANE_W-1:0] lane;

   always_comb begin
      head_mask = fifo_mask[rd_ptr];
      rest_mask = head_mask & (head_mask - LANES'(1));
      lane      = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (head_mask[i]) lane = LANE_W'(i);
      end
      have_head = (used != '0);
      count_inc = (count == '1) ? count : count + CNT_W'(1);
      push      = bus.in_valid_R18H && ready_q && ((|bus.hit_valid_R18H) || bus.tri_end_R18H);
   end

   // Beat generator: a new beat is loaded straight from the FIFO head whenever the
   // current beat advances, so consecutive groups stream without a bubble.
   always_comb begin
      state_next = state;
      hit_next   = hit_q;
      color_next = color_q;
      done_next  = done_q;
      hits_next  = hits_q;
      count_next = count;
      pop        = 1'b0;
      clear_lane = 1'b0;
      if (!bus.halt_R19H) begin
         state_next = IDLE;
         hit_next   = '0;
         color_next = '0;
         done_next  = 1'b0;
         hits_next  = '0;
         if (have_head) begin
            color_next = fifo_color[rd_ptr];
            if (head_mask != '0) begin
               state_next = SER;
               clear_lane = 1'b1;
               count_next = count_inc;
               for (int a = 0; a < AXIS; a++) begin
                  hit_next[a] = fifo_hit[rd_ptr][a][lane];
               end
               if (rest_mask == '0) begin
                  pop = 1'b1;
                  if (fifo_end[rd_ptr]) begin
                     done_next  = 1'b1;
                     hits_next  = count_inc;
                     count_next = '0;
                  end
               end
            end else begin
               state_next = TERM;
               done_next  = 1'b1;
               hits_next  = count;
               count_next = '0;
               pop        = 1'b1;
            end
         end
      end
   end

   always_comb begin
      case ({push, pop})
         2'b10:   used_next = used + UW'(1);
         2'b01:   used_next = used - UW'(1);
         default: used_next = used;
      endcase
   end

   // Ready is registered from the next occupancy, so a full FIFO refuses a push even in a pop cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         hit_q   <= '0;
         color_q <= '0;
         done_q  <= 1'b0;
         hits_q  <= '0;
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         used    <= '0;
         ready_q <= 1'b0;
      end else begin
         state   <= state_next;
         hit_q   <= hit_next;
         color_q <= color_next;
         done_q  <= done_next;
         hits_q  <= hits_next;
         count   <= count_next;
         used    <= used_next;
         ready_q <= (used_next != UW'(FIFO_DEPTH));
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_hit[wr_ptr]   <= bus.hit_R18S;
         fifo_color[wr_ptr] <= bus.color_R18U;
         fifo_mask[wr_ptr]  <= bus.hit_valid_R18H;
         fifo_end[wr_ptr]   <= bus.tri_end_R18H;
      end
      if (clear_lane) fifo_mask[rd_ptr] <= rest_mask;
   end

   assign bus.in_ready_R18H   = ready_q;
   assign bus.hit_R19S        = hit_q;
   assign bus.color_R19U      = color_q;
   assign bus.frag_valid_R19H = (state == SER);
   assign bus.done_R19H       = done_q;
   assign bus.tri_hits_R19U   = hits_q;

`ifdef FRAG_STATS_EN
   logic [CNT_W-1:0] stat_tri, stat_frag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_tri  <= '0;
         stat_frag <= '0;
      end else if (!bus.halt_R19H) begin
         if (done_q)         stat_tri  <= stat_tri + CNT_W'(1);
         if (state == SER)   stat_frag <= stat_frag + CNT_W'(1);
      end
   end

   assign bus.stat_tri_R19U  = stat_tri;
   assign bus.stat_frag_R19U = stat_frag;
`endif
endmodule

// File: tb/tb_frag_serializer.sv
// Directed bench for frag_serializer: latency, streaming, zero-hit triangles, halt hold and mid-triangle reset.
// Build with FRAG_STATS_EN defined to also check the running totals.
module tb_frag_serializer;
   localparam int SIGFIG = 24;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;
   localparam int LANES  = 4;
   localparam int CNT_W  = 32;

   typedef struct {
      logic        frag;
      logic        done;
      logic [31:0] hits;
      logic [71:0] hit;
      logic [71:0] color;
      int          cyc;
   } beat_t;

   logic  clk;
   logic  rst;
   int    cyc = 0;
   int    compared = 0;
   int    mismatched = 0;
   beat_t beats[$];

   frag_serializer_if #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .LANES(LANES), .CNT_W(CNT_W)) bus ();

   frag_serializer dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // A beat is consumed at the next rising edge when it is valid and halt is low.
   always @(negedge clk) begin
      if (rst && !bus.halt_R19H && (bus.frag_valid_R19H || bus.done_R19H)) begin
         beat_t b;
         b.frag  = bus.frag_valid_R19H;
         b.done  = bus.done_R19H;
         b.hits  = bus.tri_hits_R19U;
         b.hit   = bus.hit_R19S;
         b.color = bus.color_R19U;
         b.cyc   = cyc;
         beats.push_back(b);
      end
   end

   function automatic logic [71:0] hitOf(input int g, input int lane);
      logic [71:0] r;
      for (int a = 0; a < AXIS; a++) r[a*SIGFIG +: SIGFIG] = SIGFIG'(g*256 + a*16 + lane);
      return r;
   endfunction

   function automatic logic [71:0] colorOf(input int g);
      return {SIGFIG'(g + 3), SIGFIG'(g + 2), SIGFIG'(g + 1)};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int g, input logic [3:0] mask, input logic tri_end);
      logic accepted;
      accepted = 1'b0;
      bus.in_valid_R18H  = 1'b1;
      bus.hit_valid_R18H = mask;
      bus.tri_end_R18H   = tri_end;
      bus.color_R18U     = colorOf(g);
      for (int a = 0; a < AXIS; a++)
         for (int l = 0; l < LANES; l++)
            bus.hit_R18S[a][l] = SIGFIG'(g*256 + a*16 + l);
      for (int t = 0; t < 50; t++) begin
         accepted = bus.in_ready_R18H;
         @(posedge clk);
         #1;
         if (accepted) break;
      end
      if (!accepted) checkOutput($sformatf("push_timeout_g%0d", g), 0, 1);
      bus.in_valid_R18H = 1'b0;
   endtask

   task automatic waitBeats(input int n, input int budget, input string tag);
      int t;
      t = 0;
      while (beats.size() < n && t < budget) begin
         tick(1);
         t++;
      end
      if (beats.size() < n) checkOutput(tag, beats.size(), n);
   endtask

   task automatic checkBeat(input string tag, input int idx, input int g, input int lane,
                            input logic frag, input logic done, input int hits);
      if (idx >= beats.size()) begin
         checkOutput({tag, "_missing"}, beats.size(), idx + 1);
         return;
      end
      checkOutput({tag, "_frag"}, beats[idx].frag, frag);
      checkOutput({tag, "_done"}, beats[idx].done, done);
      if (frag) checkOutput({tag, "_hit"}, beats[idx].hit, hitOf(g, lane));
      if (done) checkOutput({tag, "_tri_hits"}, beats[idx].hits, hits);
      checkOutput({tag, "_color"}, beats[idx].color, colorOf(g));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lanes1[3];
      int exp_g[6];
      int exp_l[6];
      lanes1 = '{0, 1, 3};
      exp_g  = '{2, 2, 2, 2, 4, 4};
      exp_l  = '{0, 1, 2, 3, 0, 2};

      rst                = 1'b0;
      bus.in_valid_R18H  = 1'b0;
      bus.hit_valid_R18H = '0;
      bus.tri_end_R18H   = 1'b0;
      bus.color_R18U     = '0;
      bus.hit_R18S       = '0;
      bus.halt_R19H      = 1'b0;

      // Reset state
      @(posedge clk);
      #3;
      checkOutput("rst_ready", bus.in_ready_R18H, 0);
      checkOutput("rst_frag", bus.frag_valid_R19H, 0);
      checkOutput("rst_done", bus.done_R19H, 0);
      checkOutput("rst_tri_hits", bus.tri_hits_R19U, 0);
      checkOutput("rst_hit", bus.hit_R19S, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      tick(1);
      checkOutput("ready_after_release", bus.in_ready_R18H, 1);

      // Scenario 1: mask 1011, tri_end
      beats.delete();
      applyStimulus(1, 4'b1011, 1'b1);
      checkOutput("s1_no_beat_yet", bus.frag_valid_R19H, 0);
      tick(1);
      checkOutput("s1_first_beat", bus.frag_valid_R19H, 1);
      checkOutput("s1_first_hit", bus.hit_R19S, hitOf(1, 0));
      waitBeats(3, 20, "s1_timeout");
      tick(4);
      checkOutput("s1_beat_count", beats.size(), 3);
      for (int i = 0; i < 3; i++)
         checkBeat($sformatf("s1_b%0d", i), i, 1, lanes1[i], 1'b1, (i == 2), 3);

      // Scenario 2: 1111 / 0000 / 0101(tri_end) streams as six beats
      beats.delete();
      applyStimulus(2, 4'b1111, 1'b0);
      applyStimulus(3, 4'b0000, 1'b0);
      applyStimulus(4, 4'b0101, 1'b1);
      waitBeats(6, 30, "s2_timeout");
      tick(5);
      checkOutput("s2_beat_count", beats.size(), 6);
      for (int i = 0; i < 6; i++)
         checkBeat($sformatf("s2_b%0d", i), i, exp_g[i], exp_l[i], 1'b1, (i == 5), 6);
      for (int i = 1; i < 6; i++)
         if (i < beats.size()) checkOutput($sformatf("s2_gap%0d", i), beats[i].cyc - beats[i-1].cyc, 1);

      // Scenario 3: zero-hit triangle
      beats.delete();
      applyStimulus(5, 4'b0000, 1'b1);
      waitBeats(1, 20, "s3_timeout");
      tick(5);
      checkOutput("s3_beat_count", beats.size(), 1);
      checkBeat("s3_b0", 0, 5, 0, 1'b0, 1'b1, 0);

`ifdef FRAG_STATS_EN
      checkOutput("stat_tri", bus.stat_tri_R19U, 3);
      checkOutput("stat_frag", bus.stat_frag_R19U, 9);
`endif

      // Scenario 4: halt for five cycles while lane 1 of the first group is presented
      beats.delete();
      fork
         begin
            applyStimulus(6, 4'b1111, 1'b0);
            applyStimulus(7, 4'b1111, 1'b0);
            applyStimulus(8, 4'b1111, 1'b1);
         end
         begin
            tick(3);
            bus.halt_R19H = 1'b1;
            for (int k = 0; k < 5; k++) begin
               tick(1);
               checkOutput($sformatf("s4_hold_hit%0d", k), bus.hit_R19S, hitOf(6, 1));
               checkOutput($sformatf("s4_hold_frag%0d", k), bus.frag_valid_R19H, 1);
               checkOutput($sformatf("s4_hold_done%0d", k), bus.done_R19H, 0);
               checkOutput($sformatf("s4_hold_color%0d", k), bus.color_R19U, colorOf(6));
               checkOutput($sformatf("s4_ready_low%0d", k), bus.in_ready_R18H, 0);
            end
            bus.halt_R19H = 1'b0;
         end
      join
      waitBeats(12, 80, "s4_timeout");
      tick(5);
      checkOutput("s4_beat_count", beats.size(), 12);
      for (int i = 0; i < 12; i++)
         checkBeat($sformatf("s4_b%0d", i), i, 6 + i / 4, i % 4, 1'b1, (i == 11), 12);

      // Scenario 5: asynchronous reset mid-triangle
      beats.delete();
      applyStimulus(9, 4'b1111, 1'b1);
      waitBeats(2, 20, "s5_timeout");
      #2;
      rst = 1'b0;
      #1;
      checkOutput("s5_rst_frag", bus.frag_valid_R19H, 0);
      checkOutput("s5_rst_done", bus.done_R19H, 0);
      checkOutput("s5_rst_hit", bus.hit_R19S, 0);
      checkOutput("s5_rst_ready", bus.in_ready_R18H, 0);
      beats.delete();
      #3;
      rst = 1'b1;
      tick(1);
      checkOutput("s5_ready_after", bus.in_ready_R18H, 1);
      applyStimulus(10, 4'b0001, 1'b1);
      waitBeats(1, 20, "s5_new_timeout");
      tick(6);
      checkOutput("s5_beat_count", beats.size(), 1);
      checkBeat("s5_b0", 0, 10, 0, 1'b1, 1'b1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
